// File: rtl/mem_bus_arbiter.sv
// Purpose: arbitrates the shared memory bus between ICache (0) and DCache (1) on two independent channels (ADDR, STORE).
// Latency: a request sampled at edge t is granted at t+1; after a release, one idle cycle always precedes the next grant.
// Backpressure: the grant is held while the owner is busy; a granted owner that never goes busy loses the grant after GRANT_TIMEOUT cycles.

module arb_channel #(
   parameter int NUM_REQ       = 2,
   parameter int GRANT_TIMEOUT = 16,
   parameter int TO_W          = 5,
   parameter int IDX_W         = 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_REQ-1:0] reqcyc,
   input  logic [NUM_REQ-1:0] busy,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   owner,
   output logic               err
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_GRANTED = 2'd1,
      ST_OWNED   = 2'd2
   } state_t;

   localparam logic [TO_W-1:0]  TO_LAST  = TO_W'((GRANT_TIMEOUT > 0) ? GRANT_TIMEOUT - 1 : 0);
   localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);

   state_t             state_q, state_d;
   logic [NUM_REQ-1:0] grant_q, grant_d;
   logic [IDX_W-1:0]   owner_q, owner_d;
   logic [IDX_W-1:0]   last_q,  last_d;
   logic [TO_W-1:0]    cnt_q,   cnt_d;

   logic               win_vld;
   logic [IDX_W-1:0]   win_idx;

   // Round-robin pick: first requesting index after the last winner, wrapping around.
   always_comb begin
      win_vld = 1'b0;
      win_idx = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         int               c;
         logic [IDX_W-1:0] cand;
         c = int'(last_q) + k;
         if (c >= NUM_REQ) c = c - NUM_REQ;
         cand = IDX_W'(c);
         if (!win_vld && reqcyc[cand]) begin
            win_vld = 1'b1;
            win_idx = cand;
         end
      end
   end

   // Channel FSM next state; every exit from GRANTED/OWNED goes through IDLE so two drivers never overlap.
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      owner_d = owner_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         ST_IDLE: begin
            grant_d = '0;
            if (win_vld) begin
               grant_d          = '0;
               grant_d[win_idx] = 1'b1;
               owner_d          = win_idx;
               cnt_d            = '0;
               state_d          = ST_GRANTED;
            end
         end
         ST_GRANTED: begin
            if (busy[owner_q]) begin
               state_d = ST_OWNED;
            end else if (!reqcyc[owner_q] ||
                         ((GRANT_TIMEOUT != 0) && (cnt_q == TO_LAST))) begin
               grant_d = '0;
               last_d  = owner_q;
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q + TO_W'(1);
            end
         end
         ST_OWNED: begin
            // reqcyc is deliberately ignored here: busy alone decides how long the owner keeps the bus.
            if (!busy[owner_q]) begin
               grant_d = '0;
               last_d  = owner_q;
               state_d = ST_IDLE;
            end
         end
         default: begin
            grant_d = '0;
            state_d = ST_IDLE;
         end
      endcase
   end

   // Protocol violation: busy from anyone in IDLE, or from a non-owner while the bus is granted.
   always_comb begin
      err = 1'b0;
      if (state_q == ST_IDLE) err = |busy;
      else                    err = |(busy & ~grant_q);
   end

   // Channel state registers; the round-robin pointer resets so that requester 0 wins first.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         grant_q <= '0;
         owner_q <= '0;
         last_q  <= LAST_RST;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
      end
   end

   assign grant = grant_q;
   assign owner = owner_q;

endmodule

// Purpose: top of the memory bus arbiter; one ADDR and one STORE channel plus a shared protocol-error flag.
// Latency: grants and proto_err are registered; one cycle from sampled input to output, no combinational paths.
// Backpressure: per channel, owner busy holds the grant; unused grants time out; channels never interact.

module mem_bus_arbiter #(
   parameter int NUM_REQ       = 2,
   parameter int GRANT_TIMEOUT = 16,
   parameter int TO_W          = 5,
   parameter int IDX_W         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_REQ-1:0] addr_reqcyc,
   input  logic [NUM_REQ-1:0] addr_busy,
   output logic [NUM_REQ-1:0] addr_grant,
   input  logic [NUM_REQ-1:0] store_reqcyc,
   input  logic [NUM_REQ-1:0] store_busy,
   output logic [NUM_REQ-1:0] store_grant,
   output logic [IDX_W-1:0]   addr_owner,
   output logic [IDX_W-1:0]   store_owner,
   output logic               proto_err
);

   logic addr_err;
   logic store_err;
   logic proto_err_q, proto_err_d;

   arb_channel #(
      .NUM_REQ       (NUM_REQ),
      .GRANT_TIMEOUT (GRANT_TIMEOUT),
      .TO_W          (TO_W),
      .IDX_W         (IDX_W)
   ) u_addr (
      .clk    (clk),
      .reset  (reset),
      .reqcyc (addr_reqcyc),
      .busy   (addr_busy),
      .grant  (addr_grant),
      .owner  (addr_owner),
      .err    (addr_err)
   );

   arb_channel #(
      .NUM_REQ       (NUM_REQ),
      .GRANT_TIMEOUT (GRANT_TIMEOUT),
      .TO_W          (TO_W),
      .IDX_W         (IDX_W)
   ) u_store (
      .clk    (clk),
      .reset  (reset),
      .reqcyc (store_reqcyc),
      .busy   (store_busy),
      .grant  (store_grant),
      .owner  (store_owner),
      .err    (store_err)
   );

   // Merge per-channel violations into one flag.
   always_comb begin
      proto_err_d = addr_err | store_err;
   end

   // Register the flag so it is a clean one-cycle pulse per offending cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) proto_err_q <= 1'b0;
      else       proto_err_q <= proto_err_d;
   end

   assign proto_err = proto_err_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: round-robin, grant hold, timeout, protocol error, async reset.
// Inputs change 1 time unit after each rising edge; outputs are checked at the same point.
// Expected values are hand-derived per step.

module tb_mem_bus_arbiter;

   logic       clk;
   logic       reset;
   logic [1:0] addr_reqcyc, addr_busy, addr_grant;
   logic [1:0] store_reqcyc, store_busy, store_grant;
   logic       addr_owner, store_owner;
   logic       proto_err;

   int checks = 0;
   int errors = 0;

   mem_bus_arbiter #(
      .NUM_REQ       (2),
      .GRANT_TIMEOUT (16),
      .TO_W          (5)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .addr_reqcyc  (addr_reqcyc),
      .addr_busy    (addr_busy),
      .addr_grant   (addr_grant),
      .store_reqcyc (store_reqcyc),
      .store_busy   (store_busy),
      .store_grant  (store_grant),
      .addr_owner   (addr_owner),
      .store_owner  (store_owner),
      .proto_err    (proto_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [1:0] exp_g;

      reset        = 1'b1;
      addr_reqcyc  = 2'b00;
      addr_busy    = 2'b00;
      store_reqcyc = 2'b00;
      store_busy   = 2'b00;

      // Reset state
      tick();
      tick();
      chk("rst_addr_grant",  addr_grant,  2'b00);
      chk("rst_store_grant", store_grant, 2'b00);
      chk("rst_addr_owner",  addr_owner,  1'b0);
      chk("rst_store_owner", store_owner, 1'b0);
      chk("rst_proto_err",   proto_err,   1'b0);
      reset = 1'b0;
      tick();
      chk("idle_no_req", addr_grant, 2'b00);

      // Both request ADDR: alternate 01,10,01 with 1 GRANTED + 3 busy cycles, one gap cycle
      addr_reqcyc = 2'b11;
      for (int r = 0; r < 3; r++) begin
         exp_g = (r % 2 == 0) ? 2'b01 : 2'b10;
         tick();
         chk("rr_grant_first", addr_grant, exp_g);
         chk("rr_owner", addr_owner, (r % 2 == 0) ? 1'b0 : 1'b1);
         addr_busy = exp_g;
         for (int b = 0; b < 3; b++) begin
            tick();
            chk("rr_grant_hold", addr_grant, exp_g);
         end
         addr_busy = 2'b00;
         tick();
         chk("rr_gap", addr_grant, 2'b00);
      end
      addr_reqcyc = 2'b00;
      chk("rr_no_proto", proto_err, 1'b0);

      // ICache alone: busy 2 cycles after grant, for 5 cycles
      addr_reqcyc = 2'b01;
      tick();
      chk("ic_grant", addr_grant, 2'b01);
      tick();
      chk("ic_grant_wait", addr_grant, 2'b01);
      addr_busy = 2'b01;
      for (int b = 0; b < 5; b++) begin
         tick();
         chk("ic_grant_busy", addr_grant, 2'b01);
         chk("ic_owner", addr_owner, 1'b0);
      end
      addr_busy   = 2'b00;
      addr_reqcyc = 2'b00;
      tick();
      chk("ic_release", addr_grant, 2'b00);
      tick();
      chk("ic_stays_idle", addr_grant, 2'b00);

      // DCache STORE request, never busy: 16 cycles of grant then timeout
      store_reqcyc = 2'b10;
      tick();
      chk("to_grant", store_grant, 2'b10);
      chk("to_owner", store_owner, 1'b1);
      for (int c = 0; c < 15; c++) begin
         tick();
         chk("to_hold", store_grant, 2'b10);
      end
      tick();
      chk("to_expired", store_grant, 2'b00);
      chk("to_addr_untouched", addr_grant, 2'b00);
      tick();
      chk("to_regrant", store_grant, 2'b10);
      store_reqcyc = 2'b00;
      tick();
      chk("to_drop_release", store_grant, 2'b00);

      // Busy on an idle channel is a protocol error
      store_busy = 2'b01;
      tick();
      chk("idle_busy_proto", proto_err, 1'b1);
      store_busy = 2'b00;
      tick();
      chk("idle_busy_proto_clr", proto_err, 1'b0);
      chk("idle_busy_no_grant", store_grant, 2'b00);

      // ICache owns ADDR; DCache requests both channels
      addr_reqcyc = 2'b01;
      tick();
      chk("own_grant", addr_grant, 2'b01);
      addr_busy = 2'b01;
      tick();
      chk("own_owned", addr_grant, 2'b01);
      addr_reqcyc  = 2'b11;
      store_reqcyc = 2'b10;
      tick();
      chk("cross_store_grant", store_grant, 2'b10);
      chk("cross_addr_hold",   addr_grant,  2'b01);
      addr_busy = 2'b11;
      tick();
      chk("nonowner_proto", proto_err, 1'b1);
      chk("nonowner_grant", addr_grant, 2'b01);
      addr_busy = 2'b01;
      tick();
      chk("nonowner_proto_clr", proto_err, 1'b0);
      chk("owner_still", addr_grant, 2'b01);
      addr_busy = 2'b00;
      tick();
      chk("own_release", addr_grant, 2'b00);
      chk("own_store_hold", store_grant, 2'b10);
      tick();
      chk("dc_addr_grant", addr_grant, 2'b10);
      chk("dc_addr_owner", addr_owner, 1'b1);
      addr_busy = 2'b10;
      tick();
      chk("dc_owned", addr_grant, 2'b10);

      // Asynchronous reset mid-OWNED
      #2;
      reset = 1'b1;
      #1;
      chk("async_addr_grant",  addr_grant,  2'b00);
      chk("async_store_grant", store_grant, 2'b00);
      chk("async_addr_owner",  addr_owner,  1'b0);
      addr_busy    = 2'b00;
      addr_reqcyc  = 2'b11;
      store_reqcyc = 2'b11;
      #2;
      reset = 1'b0;
      tick();
      chk("post_rst_addr",  addr_grant,  2'b01);
      chk("post_rst_store", store_grant, 2'b01);
      chk("post_rst_owner", addr_owner,  1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
